// File: rtl/width_converter_nto8.sv
// width_converter_nto8
// Unpacks Width-bit TX queue words into a stream of bytes for the I3C TX path.
// A descriptor gives the transfer length in bytes; words are fetched one at a
// time and emitted little-endian (byte 0 = bits 7:0). Bytes of the final word
// beyond the transfer length are dropped, so a transfer consumes exactly
// ceil(len / (Width/8)) words.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   desc_valid_i/desc_ready_o     descriptor handshake, desc_len_i = byte count
//   sink_valid_i/sink_ready_o     TX queue word handshake, sink_data_i = word
//   source_valid_o/source_ready_i byte handshake, source_data_o/source_last_o
//   abort_i                       synchronous abort, wins over any handshake
//   busy_o                        high whenever a transfer is in progress
//
// Width must be a multiple of 8 and at least 16.
module width_converter_nto8 #(
  parameter int Width    = 32,
  parameter int LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                desc_valid_i,
  output logic                desc_ready_o,
  input  logic [LenWidth-1:0] desc_len_i,
  input  logic                sink_valid_i,
  output logic                sink_ready_o,
  input  logic [Width-1:0]    sink_data_i,
  output logic                source_valid_o,
  input  logic                source_ready_i,
  output logic [7:0]          source_data_o,
  output logic                source_last_o,
  input  logic                abort_i,
  output logic                busy_o
);

  localparam int NumBytes = Width / 8;
  localparam int IdxWidth = $clog2(NumBytes);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBytes - 1);
  localparam logic [LenWidth-1:0] LenOne  = LenWidth'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StEmit  = 2'd2
  } state_e;

  state_e                state_r,     state_s;
  logic [LenWidth-1:0]   remaining_r, remaining_s;
  logic [IdxWidth-1:0]   index_r,     index_s;
  logic [Width-1:0]      word_r,      word_s;
  logic [7:0]            byte_s;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= StIdle;
      remaining_r <= {LenWidth{1'b0}};
      index_r     <= {IdxWidth{1'b0}};
      word_r      <= {Width{1'b0}};
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      index_r     <= index_s;
      word_r      <= word_s;
    end
  end

  // Next-state logic; abort overrides every handshake in the same cycle.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    index_s     = index_r;
    word_s      = word_r;
    if (abort_i) begin
      state_s     = StIdle;
      remaining_s = {LenWidth{1'b0}};
      index_s     = {IdxWidth{1'b0}};
      word_s      = {Width{1'b0}};
    end else begin
      case (state_r)
        StIdle: begin
          // A zero-length descriptor is accepted and simply dropped.
          if (desc_valid_i && (desc_len_i != {LenWidth{1'b0}})) begin
            remaining_s = desc_len_i;
            state_s     = StFetch;
          end else begin
            state_s     = StIdle;
          end
        end
        StFetch: begin
          if (sink_valid_i) begin
            word_s  = sink_data_i;
            index_s = {IdxWidth{1'b0}};
            state_s = StEmit;
          end else begin
            state_s = StFetch;
          end
        end
        StEmit: begin
          if (source_ready_i) begin
            remaining_s = remaining_r - LenOne;
            if (remaining_r == LenOne) begin
              // Final byte: leftover bytes of this word are discarded.
              state_s = StIdle;
              word_s  = {Width{1'b0}};
              index_s = {IdxWidth{1'b0}};
            end else if (index_r == LastIdx) begin
              state_s = StFetch;
            end else begin
              index_s = index_r + IdxWidth'(1);
              state_s = StEmit;
            end
          end else begin
            state_s = StEmit;
          end
        end
        default: begin
          state_s     = StIdle;
          remaining_s = {LenWidth{1'b0}};
          index_s     = {IdxWidth{1'b0}};
          word_s      = {Width{1'b0}};
        end
      endcase
    end
  end

  // Byte lane select from the held word, little-endian.
  always_comb begin
    byte_s = 8'h00;
    for (int i = 0; i < NumBytes; i++) begin
      if (index_r == IdxWidth'(i)) begin
        byte_s = word_r[i*8 +: 8];
      end else begin
        byte_s = byte_s;
      end
    end
  end

  // Handshake outputs depend only on the state register, never on inputs.
  assign desc_ready_o   = (state_r == StIdle);
  assign sink_ready_o   = (state_r == StFetch);
  assign source_valid_o = (state_r == StEmit);
  assign source_data_o  = (state_r == StEmit) ? byte_s : 8'h00;
  assign source_last_o  = (state_r == StEmit) && (remaining_r == LenOne);
  assign busy_o         = (state_r != StIdle);

endmodule

// File: tb/tb_width_converter_nto8.sv
module tb_width_converter_nto8;
  localparam int Width    = 32;
  localparam int LenWidth = 16;
  localparam int B        = Width / 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                desc_valid_i;
  logic                desc_ready_o;
  logic [LenWidth-1:0] desc_len_i;
  logic                sink_valid_i;
  logic                sink_ready_o;
  logic [Width-1:0]    sink_data_i;
  logic                source_valid_o;
  logic                source_ready_i;
  logic [7:0]          source_data_o;
  logic                source_last_o;
  logic                abort_i;
  logic                busy_o;

  width_converter_nto8 #(.Width(Width), .LenWidth(LenWidth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_len_i(desc_len_i),
    .sink_valid_i(sink_valid_i), .sink_ready_o(sink_ready_o), .sink_data_i(sink_data_i),
    .source_valid_o(source_valid_o), .source_ready_i(source_ready_i),
    .source_data_o(source_data_o), .source_last_o(source_last_o),
    .abort_i(abort_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Model state: expected byte stream, bytes actually handed over, word source.
  logic [7:0]       exp_q[$];
  logic [7:0]       got_q[$];
  logic [Width-1:0] word_mem [0:63];
  int               wptr      = 0;
  logic             sink_pend = 1'b0;
  int               sink_cnt  = 0;

  assign sink_data_i = word_mem[wptr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: model is the first len bytes of the queued words, LE.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      sink_pend = 1'b0;
    end else begin
      if (source_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 64'(source_valid_o), 64'd0);
        end else begin
          check("byte_data", 64'(source_data_o), 64'(exp_q[0]));
          check("byte_last", 64'(source_last_o), 64'(exp_q.size() == 1));
          if (source_ready_i && !abort_i) begin
            got_q.push_back(source_data_o);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_data", 64'(source_data_o), 64'd0);
        check("idle_last", 64'(source_last_o), 64'd0);
      end
      if (desc_valid_i && desc_ready_o && !abort_i) begin
        got_q.delete();
        exp_q.delete();
        sink_cnt = 0;
        for (int i = 0; i < int'(desc_len_i); i++) begin
          logic [Width-1:0] w;
          w = word_mem[wptr + i / B];
          exp_q.push_back(8'(w >> (8 * (i % B))));
        end
      end
      sink_pend = sink_valid_i && sink_ready_o && !abort_i;
      if (sink_pend) sink_cnt++;
      if (abort_i) exp_q.delete();
    end
  end

  // Advance the word source after each accepted word.
  always @(posedge clk_i) begin
    if (sink_pend) wptr <= wptr + 1;
  end

  task automatic send_desc(input int len);
    desc_len_i   = LenWidth'(len);
    desc_valid_i = 1'b1;
    @(posedge clk_i); #1;
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int cnt = 0;
    while (busy_o && cnt < 200) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    if (exp_cycles >= 0) check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    else check({name, "_done"}, 64'(cnt < 200), 64'd1);
  endtask

  task automatic wait_byte(input string name, input logic [7:0] val);
    int cnt = 0;
    while (!(source_valid_o && source_data_o == val) && cnt < 50) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    check({name, "_seen"}, 64'(cnt < 50), 64'd1);
  endtask

  task automatic check_bytes(input string name, input logic [63:0] lit, input int n);
    int m;
    check({name, "_nbytes"}, 64'(got_q.size()), 64'(n));
    m = (got_q.size() < n) ? got_q.size() : n;
    for (int k = 0; k < m; k++) check({name, "_byte"}, 64'(got_q[k]), 64'(lit[8*k +: 8]));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_desc_ready"},   64'(desc_ready_o),   64'd1);
    check({name, "_sink_ready"},   64'(sink_ready_o),   64'd0);
    check({name, "_source_valid"}, 64'(source_valid_o), 64'd0);
    check({name, "_source_data"},  64'(source_data_o),  64'd0);
    check({name, "_source_last"},  64'(source_last_o),  64'd0);
    check({name, "_busy"},         64'(busy_o),         64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) word_mem[i] = '0;
    rst_ni = 1'b0; desc_valid_i = 1'b0; desc_len_i = '0;
    sink_valid_i = 1'b1; source_ready_i = 1'b1; abort_i = 1'b0;
    #12;
    check_reset_outputs("por");
    @(posedge clk_i); #3; rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("after_por");

    // len=4, one word, four bytes, last on 0x44.
    word_mem[wptr] = 32'h44332211;
    send_desc(4);
    wait_idle("len4", 5);
    check("len4_words", 64'(sink_cnt), 64'd1);
    check_bytes("len4", 64'h44332211, 4);

    // len=6 across two words, 0x77/0x88 dropped, one FETCH bubble.
    word_mem[wptr]     = 32'h44332211;
    word_mem[wptr + 1] = 32'h88776655;
    send_desc(6);
    wait_idle("len6", 8);
    check("len6_words", 64'(sink_cnt), 64'd2);
    check_bytes("len6", 64'h665544332211, 6);

    // len=0: descriptor taken, nothing else happens.
    send_desc(0);
    for (int i = 0; i < 3; i++) begin
      check("len0_sink_ready", 64'(sink_ready_o), 64'd0);
      check("len0_valid",      64'(source_valid_o), 64'd0);
      check("len0_busy",       64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
    end
    check("len0_words", 64'(sink_cnt), 64'd0);

    // len=3 with a 5-cycle stall on byte 0x22.
    word_mem[wptr] = 32'hAA332211;
    send_desc(3);
    wait_byte("hold", 8'h22);
    source_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("hold_valid", 64'(source_valid_o), 64'd1);
      check("hold_data",  64'(source_data_o),  64'h22);
      check("hold_last",  64'(source_last_o),  64'd0);
    end
    source_ready_i = 1'b1;
    wait_idle("hold", -1);
    check_bytes("hold", 64'h332211, 3);
    check("hold_words", 64'(sink_cnt), 64'd1);

    // Abort coincident with the handshake of byte 0x22, len=8.
    word_mem[wptr]     = 32'h44332211;
    word_mem[wptr + 1] = 32'h88776655;
    send_desc(8);
    wait_byte("abort", 8'h22);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort_busy",       64'(busy_o),         64'd0);
    check("abort_desc_ready", 64'(desc_ready_o),   64'd1);
    check("abort_valid",      64'(source_valid_o), 64'd0);
    repeat (3) begin
      @(posedge clk_i); #1;
      check("abort_quiet", 64'(source_valid_o), 64'd0);
    end
    check_bytes("abort", 64'h11, 1);
    check("abort_words", 64'(sink_cnt), 64'd1);

    // Reset mid-EMIT, then a fresh len=1 transfer.
    word_mem[wptr]     = 32'h44332211;
    word_mem[wptr + 1] = 32'h88776655;
    send_desc(8);
    wait_byte("rst", 8'h33);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk_i); #3; rst_ni = 1'b1;
    repeat (2) begin
      @(posedge clk_i); #1;
      check("post_rst_quiet", 64'(source_valid_o), 64'd0);
    end
    word_mem[wptr] = 32'hDDCCBB11;
    send_desc(1);
    wait_idle("len1", 2);
    check_bytes("len1", 64'h11, 1);
    check("len1_words", 64'(sink_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
